// File: rtl/eth_mdio_pkg.sv
// Shared types and constants for the MDIO arbiter and its port selector.
package eth_mdio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_ACK       = 3'd4
   } mdio_state_t;

   typedef logic [1:0] port_idx_t;

   localparam int        N_PORTS   = 3;
   localparam port_idx_t PORT_INIT = 2'd0;
   localparam port_idx_t PORT_HOST = 2'd1;
   localparam port_idx_t PORT_POLL = 2'd2;

   localparam int unsigned DEFAULT_TIMEOUT = 1023;

   // Watchdog width: wide enough for TIMEOUT, never narrower than 10 bits.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout + 1);
      return (w < 10) ? 10 : w;
   endfunction

endpackage

// File: rtl/mdio_arbiter_if.sv
// Requester-side bundle: three request ports sharing one completion channel.
interface mdio_arbiter_if;
   logic [2:0]       req;
   logic [2:0]       wr;
   logic [2:0][4:0]  addr;
   logic [2:0][15:0] wdata;
   logic [2:0]       ack;
   logic [15:0]      rdata;
   logic             err;
   logic             busy;

   modport master (output req, wr, addr, wdata, input ack, rdata, err, busy);
   modport slave  (input req, wr, addr, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/mdio_port_select.sv
// Port 0 has absolute priority; ports 1 and 2 alternate when both are asking.
module mdio_port_select
   import eth_mdio_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic [2:0] i_req,
   input  logic       i_take,
   output logic       o_valid,
   output port_idx_t  o_port
);

   logic r_pref_poll;

   always_comb begin
      o_valid = |i_req;
      o_port  = PORT_INIT;
      if (i_req[0])
         o_port = PORT_INIT;
      else if (i_req[1] && i_req[2])
         o_port = r_pref_poll ? PORT_POLL : PORT_HOST;
      else if (i_req[1])
         o_port = PORT_HOST;
      else if (i_req[2])
         o_port = PORT_POLL;
   end

   // A port-0 grant leaves the host/poller preference untouched.
   always_ff @(posedge i_clock) begin
      if (i_reset)
         r_pref_poll <= 1'b0;
      else if (i_take) begin
         if (o_port == PORT_HOST)
            r_pref_poll <= 1'b1;
         else if (o_port == PORT_POLL)
            r_pref_poll <= 1'b0;
      end
   end

endmodule

// File: rtl/mdio_arbiter.sv
// Shares one MDIO engine between PHY init, host access and status poller.
// state     | meaning
// IDLE      | no owner; grant when engine ready and a port requests
// ISSUE     | one-cycle rd/wr strobe to the engine with latched fields
// WAIT_BUSY | waiting for the engine to drop ready
// WAIT_DONE | waiting for the engine to raise ready again
// ACK       | one-cycle ack to the owner with rdata/err
module mdio_arbiter
   import eth_mdio_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
)(
   input  logic          i_clock,
   input  logic          i_reset,
   mdio_arbiter_if.slave if_port,
   input  logic          i_mdio_ready,
   input  logic [15:0]   i_mdio_rd_data,
   output logic [4:0]    o_mdio_addr,
   output logic [15:0]   o_mdio_wdata,
   output logic          o_mdio_rd_request,
   output logic          o_mdio_wr_request
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT);

   mdio_state_t      r_state;
   mdio_state_t      w_next;
   port_idx_t        r_port;
   logic             r_wr;
   logic [4:0]       r_addr;
   logic [15:0]      r_wdata;
   logic [15:0]      r_rdata;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   logic      w_sel_valid;
   port_idx_t w_sel_port;
   logic      w_take;
   logic      w_timeout;

   mdio_port_select u_sel (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_req   (if_port.req),
      .i_take  (w_take),
      .o_valid (w_sel_valid),
      .o_port  (w_sel_port)
   );

   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

   always_comb begin
      w_next = r_state;
      w_take = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_mdio_ready && w_sel_valid) begin
               w_take = 1'b1;
               w_next = ST_ISSUE;
            end
         end
         ST_ISSUE:     w_next = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (w_timeout)
               w_next = ST_ACK;
            else if (!i_mdio_ready)
               w_next = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (w_timeout || i_mdio_ready)
               w_next = ST_ACK;
         end
         ST_ACK:       w_next = ST_IDLE;
         default:      w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_port  <= PORT_INIT;
         r_wr    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_port  <= w_sel_port;
            r_wr    <= if_port.wr[w_sel_port];
            r_addr  <= if_port.addr[w_sel_port];
            r_wdata <= if_port.wdata[w_sel_port];
         end
         case (r_state)
            ST_ISSUE: begin
               r_cnt   <= '0;
               r_rdata <= '0;
               r_err   <= 1'b0;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_timeout) begin
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else if (r_state == ST_WAIT_DONE && i_mdio_ready && !r_wr)
                  r_rdata <= i_mdio_rd_data;
            end
            default: ;
         endcase
      end
   end

   assign o_mdio_addr       = r_addr;
   assign o_mdio_wdata      = r_wdata;
   assign o_mdio_rd_request = (r_state == ST_ISSUE) && !r_wr;
   assign o_mdio_wr_request = (r_state == ST_ISSUE) && r_wr;

   // Completion channel is forced quiet outside the ACK cycle.
   assign if_port.ack   = (r_state == ST_ACK) ? (3'b001 << r_port) : 3'b000;
   assign if_port.rdata = (r_state == ST_ACK) ? r_rdata : 16'h0000;
   assign if_port.err   = (r_state == ST_ACK) ? r_err : 1'b0;
   assign if_port.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed bench for mdio_arbiter with a simple behavioural MDIO engine.
module tb_mdio_arbiter;
   import eth_mdio_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ready = 1'b1;
   logic [15:0] rd_data = 16'h0000;
   logic [4:0]  m_addr;
   logic [15:0] m_wdata;
   logic        m_rd;
   logic        m_wr;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   mdio_arbiter_if bus();

   mdio_arbiter #(.TIMEOUT(1023)) dut (
      .i_clock           (clk),
      .i_reset           (rst),
      .if_port           (bus.slave),
      .i_mdio_ready      (ready),
      .i_mdio_rd_data    (rd_data),
      .o_mdio_addr       (m_addr),
      .o_mdio_wdata      (m_wdata),
      .o_mdio_rd_request (m_rd),
      .o_mdio_wr_request (m_wr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        rd;
      logic        wr;
      logic [4:0]  addr;
      logic [15:0] wdata;
   } strobe_t;

   typedef struct {
      int          cyc;
      logic [2:0]  ack;
      logic [15:0] rdata;
      logic        err;
   } ack_t;

   strobe_t sq[$];
   ack_t    aq[$];

   always @(negedge clk) begin
      cyc++;
      if (m_rd || m_wr)
         sq.push_back('{cyc, m_rd, m_wr, m_addr, m_wdata});
      if (|bus.ack)
         aq.push_back('{cyc, bus.ack, bus.rdata, bus.err});
   end

   // Requesters: each port keeps req high until it has seen pend[p] acks.
   int pend[3] = '{0, 0, 0};
   always @(negedge clk) begin
      for (int p = 0; p < 3; p++) begin
         if (bus.ack[p] && pend[p] > 0) begin
            pend[p]--;
            if (pend[p] == 0) bus.req[p] = 1'b0;
         end
      end
   end

   // Engine model: drops ready for eng_busy cycles after each strobe.
   logic        eng_hang = 1'b0;
   int          eng_busy = 3;
   logic [15:0] eng_data = 16'h0000;
   always begin
      @(negedge clk);
      if ((m_rd || m_wr) && !eng_hang) begin
         ready = 1'b0;
         repeat (eng_busy) @(negedge clk);
         rd_data = eng_data;
         ready = 1'b1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.req = 3'b000;
      for (int p = 0; p < 3; p++) pend[p] = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sq.delete();
      aq.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b want 000", bus.ack); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
      checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
      checks++; if ({m_rd, m_wr} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {m_rd, m_wr}); end
      checks++; if (m_addr !== 5'd0) begin errors++; $display("FAIL reset_maddr: got %h want 00", m_addr); end
      checks++; if (m_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mwdata: got %h want 0000", m_wdata); end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      int k = 0;
      apply_reset();
      eng_busy = 40;
      eng_data = 16'h796D;
      bus.wr[1] = 1'b0;
      bus.addr[1] = 5'd1;
      pend[1] = 1;
      bus.req[1] = 1'b1;
      while (aq.size() < 1 && k < 200) begin @(negedge clk); k++; end
      repeat (5) @(negedge clk);
      checks++; if (aq.size() != 1) begin errors++; $display("FAIL rd_ack_count: got %0d want 1", aq.size()); end
      checks++; if (sq.size() != 1) begin errors++; $display("FAIL rd_strobe_count: got %0d want 1", sq.size()); end
      checks++; if ({sq[0].rd, sq[0].wr} !== 2'b10) begin errors++; $display("FAIL rd_strobe_kind: got %b want 10", {sq[0].rd, sq[0].wr}); end
      checks++; if (sq[0].addr !== 5'd1) begin errors++; $display("FAIL rd_addr: got %h want 01", sq[0].addr); end
      checks++; if (aq[0].ack !== 3'b010) begin errors++; $display("FAIL rd_ack: got %b want 010", aq[0].ack); end
      checks++; if (aq[0].rdata !== 16'h796D) begin errors++; $display("FAIL rd_rdata: got %h want 796d", aq[0].rdata); end
      checks++; if (aq[0].err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", aq[0].err); end
   endtask

   task automatic test_priority();
      int k = 0;
      apply_reset();
      eng_busy = 3;
      eng_data = 16'hA5A5;
      bus.wr = 3'b001;
      bus.addr[0] = 5'd0;  bus.wdata[0] = 16'h1300;
      bus.addr[1] = 5'd2;  bus.wdata[1] = 16'h0000;
      bus.addr[2] = 5'd3;  bus.wdata[2] = 16'h0000;
      pend[0] = 1; pend[1] = 1; pend[2] = 1;
      bus.req = 3'b111;
      while (aq.size() < 3 && k < 200) begin @(negedge clk); k++; end
      checks++; if (aq.size() != 3) begin errors++; $display("FAIL prio_ack_count: got %0d want 3", aq.size()); end
      checks++; if (aq[0].ack !== 3'b001) begin errors++; $display("FAIL prio_grant0: got %b want 001", aq[0].ack); end
      checks++; if (aq[1].ack !== 3'b010) begin errors++; $display("FAIL prio_grant1: got %b want 010", aq[1].ack); end
      checks++; if (aq[2].ack !== 3'b100) begin errors++; $display("FAIL prio_grant2: got %b want 100", aq[2].ack); end
      checks++; if ({sq[0].rd, sq[0].wr} !== 2'b01) begin errors++; $display("FAIL prio_wr_kind: got %b want 01", {sq[0].rd, sq[0].wr}); end
      checks++; if (sq[0].wdata !== 16'h1300) begin errors++; $display("FAIL prio_wdata: got %h want 1300", sq[0].wdata); end
      checks++; if (sq[0].addr !== 5'd0) begin errors++; $display("FAIL prio_addr0: got %h want 00", sq[0].addr); end
      checks++; if (sq[1].addr !== 5'd2) begin errors++; $display("FAIL prio_addr1: got %h want 02", sq[1].addr); end
      checks++; if (sq[2].addr !== 5'd3) begin errors++; $display("FAIL prio_addr2: got %h want 03", sq[2].addr); end
      checks++; if (aq[0].rdata !== 16'h0000) begin errors++; $display("FAIL prio_wr_rdata: got %h want 0000", aq[0].rdata); end
      checks++; if (aq[1].rdata !== 16'hA5A5) begin errors++; $display("FAIL prio_rd_rdata: got %h want a5a5", aq[1].rdata); end
      bus.wr = 3'b000;
   endtask

   task automatic test_back_to_back();
      int k = 0;
      logic [2:0] exp_ack [4] = '{3'b010, 3'b100, 3'b010, 3'b100};
      apply_reset();
      eng_busy = 2;
      eng_data = 16'h5A5A;
      bus.wr = 3'b000;
      bus.addr[1] = 5'd4;
      bus.addr[2] = 5'd5;
      pend[1] = 2; pend[2] = 2;
      bus.req = 3'b110;
      while (aq.size() < 4 && k < 300) begin @(negedge clk); k++; end
      repeat (5) @(negedge clk);
      checks++; if (sq.size() != 4) begin errors++; $display("FAIL rr_strobe_count: got %0d want 4", sq.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (aq[i].ack !== exp_ack[i]) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, aq[i].ack, exp_ack[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (sq[i+1].cyc - aq[i].cyc != 2) begin errors++; $display("FAIL b2b_gap%0d: got %0d want 2", i, sq[i+1].cyc - aq[i].cyc); end
      end
   endtask

   task automatic test_timeout();
      int k = 0;
      apply_reset();
      eng_hang = 1'b1;
      bus.wr = 3'b000;
      bus.addr[1] = 5'd7;
      pend[1] = 1;
      bus.req[1] = 1'b1;
      while (aq.size() < 1 && k < 1200) begin @(negedge clk); k++; end
      checks++; if (aq.size() != 1) begin errors++; $display("FAIL to_ack_count: got %0d want 1", aq.size()); end
      checks++; if (aq[0].cyc - sq[0].cyc != 1025) begin errors++; $display("FAIL to_latency: got %0d want 1025", aq[0].cyc - sq[0].cyc); end
      checks++; if (aq[0].err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", aq[0].err); end
      checks++; if (aq[0].rdata !== 16'h0000) begin errors++; $display("FAIL to_rdata: got %h want 0000", aq[0].rdata); end
      checks++; if (aq[0].ack !== 3'b010) begin errors++; $display("FAIL to_ack: got %b want 010", aq[0].ack); end
      eng_hang = 1'b0;
      eng_busy = 3;
      eng_data = 16'h1234;
      bus.addr[2] = 5'd8;
      pend[2] = 1;
      bus.req[2] = 1'b1;
      k = 0;
      while (aq.size() < 2 && k < 100) begin @(negedge clk); k++; end
      checks++; if (aq[1].ack !== 3'b100) begin errors++; $display("FAIL to_next_ack: got %b want 100", aq[1].ack); end
      checks++; if (aq[1].err !== 1'b0) begin errors++; $display("FAIL to_next_err: got %b want 0", aq[1].err); end
      checks++; if (aq[1].rdata !== 16'h1234) begin errors++; $display("FAIL to_next_rdata: got %h want 1234", aq[1].rdata); end
   endtask

   task automatic test_reset_mid();
      int k = 0;
      apply_reset();
      eng_busy = 50;
      eng_data = 16'hBEEF;
      bus.wr = 3'b000;
      bus.addr[1] = 5'd10;
      pend[1] = 1;
      bus.req[1] = 1'b1;
      while (sq.size() < 1 && k < 20) begin @(negedge clk); k++; end
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
      checks++; if (bus.ack !== 3'b000) begin errors++; $display("FAIL rmid_ack: got %b want 000", bus.ack); end
      checks++; if (m_addr !== 5'd0) begin errors++; $display("FAIL rmid_maddr: got %h want 00", m_addr); end
      checks++; if ({m_rd, m_wr, bus.err} !== 3'b000) begin errors++; $display("FAIL rmid_strobe_err: got %b want 000", {m_rd, m_wr, bus.err}); end
      rst = 1'b0;
      eng_busy = 3;
      repeat (10) @(negedge clk);
      checks++; if (sq.size() != 1) begin errors++; $display("FAIL rmid_no_grant: got %0d strobes want 1", sq.size()); end
      checks++; if (aq.size() != 0) begin errors++; $display("FAIL rmid_no_ack: got %0d acks want 0", aq.size()); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b want 0", bus.busy); end
      k = 0;
      while (aq.size() < 1 && k < 150) begin @(negedge clk); k++; end
      checks++; if (sq.size() != 2) begin errors++; $display("FAIL rmid_regrant: got %0d strobes want 2", sq.size()); end
      checks++; if (aq[0].rdata !== 16'hBEEF) begin errors++; $display("FAIL rmid_rdata: got %h want beef", aq[0].rdata); end
      checks++; if (aq[0].ack !== 3'b010) begin errors++; $display("FAIL rmid_ack_port: got %b want 010", aq[0].ack); end
   endtask

   task automatic test_drop_req();
      int k = 0;
      apply_reset();
      eng_busy = 10;
      eng_data = 16'h0F0F;
      bus.wr = 3'b000;
      bus.addr[2] = 5'd9;
      pend[2] = 1;
      bus.req[2] = 1'b1;
      while (sq.size() < 1 && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      bus.req[2] = 1'b0;
      k = 0;
      while (aq.size() < 1 && k < 100) begin @(negedge clk); k++; end
      repeat (20) @(negedge clk);
      checks++; if (aq.size() != 1) begin errors++; $display("FAIL drop_ack_count: got %0d want 1", aq.size()); end
      checks++; if (aq[0].ack !== 3'b100) begin errors++; $display("FAIL drop_ack: got %b want 100", aq[0].ack); end
      checks++; if (aq[0].rdata !== 16'h0F0F) begin errors++; $display("FAIL drop_rdata: got %h want 0f0f", aq[0].rdata); end
      checks++; if (sq.size() != 1) begin errors++; $display("FAIL drop_reissue: got %0d strobes want 1", sq.size()); end
   endtask

   initial begin
      bus.req   = 3'b000;
      bus.wr    = 3'b000;
      bus.addr  = '0;
      bus.wdata = '0;
      test_reset();
      test_single_read();
      test_priority();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      test_drop_req();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, max clock cycles allowed for one MDIO transaction (issue to completion) before abort.
REQ-002 clock  in  1  MDIO system clock (2.5 MHz), all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  3  per-port request level; port 0 = PHY init, port 1 = host register access, port 2 = status poller.
REQ-005 wr  in  3  per-port transaction type, 1 = write, 0 = read; sampled with req.
REQ-006 addr  in  3x5  per-port MDIO register address.
REQ-007 wdata  in  3x16  per-port write data.
REQ-008 ack  out  3  per-port one-cycle completion pulse.
REQ-009 rdata  out  16  read data of the completed transaction; valid while any ack bit is high.
REQ-010 err  out  1  high with ack when the transaction timed out.
REQ-011 busy  out  1  high while a transaction is owned by any port.
REQ-012 mdio_addr  out  5  address to MDIO engine.
REQ-013 mdio_wdata  out  16  write data to MDIO engine.
REQ-014 mdio_rd_request, mdio_wr_request  out  1 each  one-cycle request strobes to MDIO engine.
REQ-015 mdio_ready  in  1  MDIO engine idle; low while a transaction runs.
REQ-016 mdio_rd_data  in  16  MDIO engine read result, valid when mdio_ready returns high.

Function
REQ-017 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK.
REQ-018 IDLE: when mdio_ready=1 and any req bit set, SHALL grant one port, latch its wr/addr/wdata into registers, go to ISSUE; mdio_ready=0 SHALL hold IDLE.
REQ-019 Port 0 SHALL win over ports 1 and 2 unconditionally.
REQ-020 Ports 1 and 2 SHALL round-robin: after a port-1 grant port 2 is preferred next, and vice versa; preference pointer resets to port 1.
REQ-021 ISSUE: SHALL assert exactly one of mdio_rd_request/mdio_wr_request for one cycle with latched addr/wdata, then go to WAIT_BUSY.
REQ-022 mdio_addr/mdio_wdata SHALL hold latched values from ISSUE until ACK.
REQ-023 WAIT_BUSY: on mdio_ready=0 SHALL go to WAIT_DONE.
REQ-024 WAIT_DONE: on mdio_ready=1 SHALL capture mdio_rd_data into rdata (reads only; writes leave rdata 0) and go to ACK.
REQ-025 A 10-bit-minimum cycle counter SHALL clear in ISSUE and increment in WAIT_BUSY/WAIT_DONE; at count = TIMEOUT SHALL go to ACK with err=1, rdata=16'h0000.
REQ-026 ACK: SHALL pulse ack bit of the granted port for one cycle with rdata/err, then return to IDLE; rdata/err SHALL be 0 outside ACK.
REQ-027 Requester SHALL hold req and fields stable until its ack; req still high in the cycle after ack SHALL be treated as a new request.
REQ-028 req dropped before ack SHALL NOT abort the in-flight transaction; ack still pulses.
REQ-029 Minimum back-to-back spacing: IDLE to next ISSUE SHALL take one cycle, i.e. no grant in the ACK cycle.
REQ-030 busy SHALL be 1 in ISSUE, WAIT_BUSY, WAIT_DONE, ACK; 0 in IDLE.

Reset
REQ-031 reset SHALL force state IDLE, ack=0, err=0, rdata=0, busy=0, both mdio request strobes 0, mdio_addr=0, mdio_wdata=0, counter 0, round-robin pointer to port 1.
REQ-032 reset mid-transaction SHALL drop ownership without ack; the first grant after reset SHALL wait for mdio_ready=1 (REQ-018).

Structure
REQ-033 State enum, port indices and default TIMEOUT SHALL live in shared package eth_mdio_pkg.
REQ-034 Priority/round-robin select SHALL be one sub-module, mdio_port_select; MDIO engine SHALL be instantiated outside this block.

Verification
REQ-035 Port 1 read addr 1, engine model returns 16'h796D after 40 busy cycles -> one rd strobe addr 1, ack[1] one cycle with rdata=16'h796D, err=0.
REQ-036 Ports 0,1,2 request simultaneously (port 0 write reg 0 = 16'h1300) -> grant order 0,1,2; mdio_wdata=16'h1300 on first strobe.
REQ-037 Ports 1 and 2 held high for 4 transactions -> grants 1,2,1,2.
REQ-038 Engine never drops mdio_ready after strobe, TIMEOUT=1023 -> ack with err=1, rdata=0 at counter 1023, next request served normally.
REQ-039 reset asserted in WAIT_DONE -> no ack, all outputs 0 next cycle; pending req with mdio_ready=0 not granted until mdio_ready=1.
REQ-040 Port 2 drops req mid-transaction -> transaction completes, ack[2] pulses once, no re-issue.
